// File: rtl/fifoprog.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, optional first-word-fall-through read, synchronous flush and sticky error flags.
module fifoprog #(
  parameter int DW     = 16,
  parameter int AW     = 4,
  parameter int FWFT   = 0,
  parameter int AFULL  = 2**AW - 2,
  parameter int AEMPTY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam int          DEPTH     = 2**AW;
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C   = (AW+1)'(AFULL);
  localparam logic [AW:0] AEMPTY_C  = (AW+1)'(AEMPTY);
  localparam logic [AW:0] COUNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam bit          FWFT_MODE = (FWFT != 0);

  if (AFULL < 1 || AFULL > DEPTH) begin : g_bad_afull
    $error("fifoprog: AFULL=%0d outside 1..%0d", AFULL, DEPTH);
  end
  if (AEMPTY < 0 || AEMPTY > DEPTH - 1) begin : g_bad_aempty
    $error("fifoprog: AEMPTY=%0d outside 0..%0d", AEMPTY, DEPTH - 1);
  end

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0] head;
  logic          wr_acc, rd_acc;

  // Flags come only from the registered count, never from the request inputs.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign head   = mem[rd_ptr_q];
  assign wr_acc = wr_en && !full && !clear;
  assign rd_acc = rd_en && !empty && !clear;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rd_valid_d  = rd_acc;
    rd_data_d   = rd_data_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en && !wr_acc) overflow_d  = 1'b1;
      if (rd_en && !rd_acc) underflow_d = 1'b1;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + COUNT_ONE;
        2'b01:   count_d = count_q - COUNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // In FWFT mode the register shadows the visible head so rd_data holds once empty.
    if (FWFT_MODE ? !empty : rd_acc) rd_data_d = head;
  end

  assign rd_valid = FWFT_MODE ? !empty : rd_valid_q;
  assign rd_data  = (FWFT_MODE && !empty) ? head : rd_data_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // NOTE: storage has no reset; stale words are unreachable because pointers and count are reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_fifoprog.sv
// Directed bench for fifoprog: a standard-mode instance (AFULL=12, AEMPTY=2) and an FWFT instance.
module tb_fifoprog;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        s_clear = 1'b0, s_wr_en = 1'b0, s_rd_en = 1'b0;
  logic [15:0] s_wr_data = '0;
  logic [15:0] s_rd_data;
  logic        s_rd_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic [4:0]  s_count;

  logic        f_clear = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
  logic [15:0] f_wr_data = '0;
  logic [15:0] f_rd_data;
  logic        f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [4:0]  f_count;

  int errors = 0;
  int checks = 0;

  localparam logic [27:0] RST_VEC = {16'h0000, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
  wire [27:0] s_vec = {s_rd_data, s_rd_valid, s_full, s_empty, s_count, s_afull, s_aempty, s_ovf, s_udf};
  wire [27:0] f_vec = {f_rd_data, f_rd_valid, f_full, f_empty, f_count, f_afull, f_aempty, f_ovf, f_udf};

  fifoprog #(.DW(16), .AW(4), .FWFT(0), .AFULL(12), .AEMPTY(2)) u_std (
    .clk(clk), .rst_n(rst_n), .clear(s_clear), .wr_en(s_wr_en), .wr_data(s_wr_data),
    .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
    .empty(s_empty), .count(s_count), .almost_full(s_afull), .almost_empty(s_aempty),
    .overflow(s_ovf), .underflow(s_udf)
  );

  fifoprog #(.DW(16), .AW(4), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .clear(f_clear), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
    .empty(f_empty), .count(f_count), .almost_full(f_afull), .almost_empty(f_aempty),
    .overflow(f_ovf), .underflow(f_udf)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (s_vec !== RST_VEC) begin
      errors++; $display("FAIL reset_std: got %h expected %h", s_vec, RST_VEC);
    end
    checks++;
    if (f_vec !== RST_VEC) begin
      errors++; $display("FAIL reset_fwft: got %h expected %h", f_vec, RST_VEC);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++;
    if (s_vec !== RST_VEC) begin
      errors++; $display("FAIL reset_release_idle: got %h expected %h", s_vec, RST_VEC);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      s_wr_en = 1'b1; s_wr_data = 16'(i);
      tick();
    end
    s_wr_en = 1'b0;
    checks++;
    if ({s_full, s_count} !== {1'b1, 5'd16}) begin
      errors++; $display("FAIL fill_full_count: got full=%b count=%0d expected full=1 count=16", s_full, s_count);
    end
    for (int i = 0; i < 16; i++) begin
      s_rd_en = 1'b1;
      tick();
      checks++;
      if ({s_rd_valid, s_rd_data} !== {1'b1, 16'(i)}) begin
        errors++; $display("FAIL drain_word%0d: got valid=%b data=%h expected valid=1 data=%h", i, s_rd_valid, s_rd_data, 16'(i));
      end
    end
    s_rd_en = 1'b0;
    checks++;
    if ({s_empty, s_ovf, s_udf} !== 3'b100) begin
      errors++; $display("FAIL drain_end_flags: got empty/ovf/udf=%b expected 100", {s_empty, s_ovf, s_udf});
    end
    tick();
    checks++;
    if ({s_rd_valid, s_rd_data} !== {1'b0, 16'd15}) begin
      errors++; $display("FAIL idle_hold: got valid=%b data=%h expected valid=0 data=000f", s_rd_valid, s_rd_data);
    end
  endtask

  task automatic test_thresholds();
    int cnt;
    for (int i = 0; i < 12; i++) begin
      s_wr_en = 1'b1; s_wr_data = 16'h0100 + 16'(i);
      tick();
      cnt = i + 1;
      checks++;
      if ({s_afull, s_aempty} !== {1'(cnt >= 12), 1'(cnt <= 2)}) begin
        errors++; $display("FAIL thr_write_cnt%0d: got af=%b ae=%b expected af=%b ae=%b", cnt, s_afull, s_aempty, cnt >= 12, cnt <= 2);
      end
    end
    s_wr_en = 1'b0;
    for (int j = 0; j < 12; j++) begin
      s_rd_en = 1'b1;
      tick();
      cnt = 11 - j;
      checks++;
      if ({s_afull, s_aempty, s_rd_data} !== {1'(cnt >= 12), 1'(cnt <= 2), 16'h0100 + 16'(j)}) begin
        errors++; $display("FAIL thr_read_cnt%0d: got af=%b ae=%b data=%h expected af=%b ae=%b data=%h",
                           cnt, s_afull, s_aempty, s_rd_data, cnt >= 12, cnt <= 2, 16'h0100 + 16'(j));
      end
    end
    s_rd_en = 1'b0;
    tick();
  endtask

  task automatic test_collisions();
    for (int i = 0; i < 16; i++) begin
      s_wr_en = 1'b1; s_wr_data = 16'h0200 + 16'(i);
      tick();
    end
    s_rd_en = 1'b1; s_wr_data = 16'hAAAA;
    tick();
    s_wr_en = 1'b0;
    checks++;
    if ({s_count, s_ovf, s_rd_valid, s_rd_data} !== {5'd15, 1'b1, 1'b1, 16'h0200}) begin
      errors++; $display("FAIL full_collision: got count=%0d ovf=%b valid=%b data=%h expected 15 1 1 0200",
                         s_count, s_ovf, s_rd_valid, s_rd_data);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++;
      if ({s_rd_valid, s_rd_data} !== {1'b1, 16'h0200 + 16'(i)}) begin
        errors++; $display("FAIL full_collision_drain%0d: got valid=%b data=%h expected valid=1 data=%h",
                           i, s_rd_valid, s_rd_data, 16'h0200 + 16'(i));
      end
    end
    s_wr_en = 1'b1; s_wr_data = 16'h5555;
    tick();
    s_wr_en = 1'b0; s_rd_en = 1'b0;
    checks++;
    if ({s_count, s_rd_valid, s_udf} !== {5'd1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL empty_collision: got count=%0d valid=%b udf=%b expected 1 0 1", s_count, s_rd_valid, s_udf);
    end
    s_rd_en = 1'b1;
    tick();
    s_rd_en = 1'b0;
    checks++;
    if ({s_rd_valid, s_rd_data} !== {1'b1, 16'h5555}) begin
      errors++; $display("FAIL empty_collision_word: got valid=%b data=%h expected valid=1 data=5555", s_rd_valid, s_rd_data);
    end
    s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    checks++;
    if ({s_ovf, s_udf, s_count} !== 7'd0) begin
      errors++; $display("FAIL collision_clear: got ovf=%b udf=%b count=%0d expected 0 0 0", s_ovf, s_udf, s_count);
    end
  endtask

  task automatic test_fwft();
    f_wr_en = 1'b1; f_wr_data = 16'h1234;
    tick();
    checks++;
    if ({f_rd_valid, f_rd_data, f_count} !== {1'b1, 16'h1234, 5'd1}) begin
      errors++; $display("FAIL fwft_first: got valid=%b data=%h count=%0d expected 1 1234 1", f_rd_valid, f_rd_data, f_count);
    end
    f_wr_data = 16'h5678;
    tick();
    f_wr_en = 1'b0;
    checks++;
    if ({f_rd_valid, f_rd_data} !== {1'b1, 16'h1234}) begin
      errors++; $display("FAIL fwft_head_stable: got valid=%b data=%h expected 1 1234", f_rd_valid, f_rd_data);
    end
    f_rd_en = 1'b1;
    tick();
    checks++;
    if ({f_rd_valid, f_rd_data} !== {1'b1, 16'h5678}) begin
      errors++; $display("FAIL fwft_pop1: got valid=%b data=%h expected 1 5678", f_rd_valid, f_rd_data);
    end
    tick();
    f_rd_en = 1'b0;
    checks++;
    if ({f_rd_valid, f_rd_data, f_empty, f_udf} !== {1'b0, 16'h5678, 1'b1, 1'b0}) begin
      errors++; $display("FAIL fwft_pop2: got valid=%b data=%h empty=%b udf=%b expected 0 5678 1 0",
                         f_rd_valid, f_rd_data, f_empty, f_udf);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] q[$];
    logic [15:0] exp;
    logic        do_wr, do_rd;
    int          n;
    n = 0;
    for (int i = 0; i < 2; i++) begin
      s_wr_en = 1'b1; s_wr_data = 16'h3000 + 16'(n);
      q.push_back(s_wr_data); n++;
      tick();
    end
    // Occupancy cycles 3,3,2,2 while pointers wrap repeatedly.
    for (int i = 0; i < 64; i++) begin
      do_wr = (i % 4 != 2);
      do_rd = (i % 4 != 0);
      s_wr_en = do_wr; s_rd_en = do_rd; s_wr_data = 16'h3000 + 16'(n);
      exp = '0;
      if (do_rd) exp = q.pop_front();
      if (do_wr) begin q.push_back(s_wr_data); n++; end
      tick();
      checks++;
      if (s_count !== 5'(q.size()) || s_count > 5'd3) begin
        errors++; $display("FAIL wrap_count%0d: got %0d expected %0d", i, s_count, q.size());
      end
      if (do_rd) begin
        checks++;
        if ({s_rd_valid, s_rd_data} !== {1'b1, exp}) begin
          errors++; $display("FAIL wrap_data%0d: got valid=%b data=%h expected valid=1 data=%h", i, s_rd_valid, s_rd_data, exp);
        end
      end
    end
    s_wr_en = 1'b0;
    while (q.size() > 0) begin
      s_rd_en = 1'b1;
      exp = q.pop_front();
      tick();
      checks++;
      if (s_rd_data !== exp) begin
        errors++; $display("FAIL wrap_drain: got %h expected %h", s_rd_data, exp);
      end
    end
    s_rd_en = 1'b0;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 17; i++) begin
      s_wr_en = 1'b1; s_wr_data = 16'h0400 + 16'(i);
      tick();
    end
    s_wr_en = 1'b0;
    s_rd_en = 1'b1;
    repeat (11) tick();
    s_rd_en = 1'b0;
    checks++;
    if ({s_count, s_ovf} !== {5'd5, 1'b1}) begin
      errors++; $display("FAIL clear_setup: got count=%0d ovf=%b expected 5 1", s_count, s_ovf);
    end
    s_clear = 1'b1; s_wr_en = 1'b1; s_wr_data = 16'hBEEF;
    tick();
    s_clear = 1'b0; s_wr_en = 1'b0;
    checks++;
    if ({s_count, s_empty, s_ovf, s_rd_valid} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL clear_state: got count=%0d empty=%b ovf=%b valid=%b expected 0 1 0 0",
                         s_count, s_empty, s_ovf, s_rd_valid);
    end
    tick();
    checks++;
    if (s_count !== 5'd0) begin
      errors++; $display("FAIL clear_write_dropped: got count=%0d expected 0", s_count);
    end
    s_wr_en = 1'b1; s_wr_data = 16'h0C0C;
    tick();
    s_wr_en = 1'b0; s_rd_en = 1'b1;
    tick();
    s_rd_en = 1'b0;
    checks++;
    if ({s_rd_valid, s_rd_data} !== {1'b1, 16'h0C0C}) begin
      errors++; $display("FAIL clear_then_write: got valid=%b data=%h expected 1 0c0c", s_rd_valid, s_rd_data);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      s_wr_en = 1'b1; s_wr_data = 16'h5000 + 16'(i); s_rd_en = (i > 0);
      f_wr_en = 1'b1; f_wr_data = 16'h6000 + 16'(i);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s_vec !== RST_VEC) begin
      errors++; $display("FAIL async_reset_std: got %h expected %h", s_vec, RST_VEC);
    end
    checks++;
    if (f_vec !== RST_VEC) begin
      errors++; $display("FAIL async_reset_fwft: got %h expected %h", f_vec, RST_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    s_rd_en = 1'b0; s_wr_data = 16'h7777; f_wr_data = 16'h7777;
    tick();
    s_wr_en = 1'b0; f_wr_en = 1'b0;
    checks++;
    if (s_count !== 5'd1) begin
      errors++; $display("FAIL reset_first_write_std: got count=%0d expected 1", s_count);
    end
    checks++;
    if ({f_rd_valid, f_rd_data} !== {1'b1, 16'h7777}) begin
      errors++; $display("FAIL reset_first_write_fwft: got valid=%b data=%h expected 1 7777", f_rd_valid, f_rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_thresholds();
    test_collisions();
    test_fwft();
    test_wrap();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
